// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch unit and the control unit: opcodes,
// fetch FSM encoding, default widths and the PC command bundle.
package instr_fetch_unit_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   localparam logic [7:0] OP_JMP  = 8'h81;
   localparam logic [7:0] OP_CALL = 8'h82;
   localparam logic [7:0] OP_RET  = 8'h83;

   typedef enum logic {
      IFU_IDLE = 1'b0,
      IFU_WAIT = 1'b1
   } ifu_state_t;

   // One cycle's worth of PC commands from the control unit.
   typedef struct packed {
      logic ret;
      logic call;
      logic jmp;
      logic inc;
   } pc_cmd_t;

endpackage

// File: rtl/instr_fetch_unit_ret_stack.sv
// Return-address LIFO. Pure storage: the caller decides when to push/pop.
// sp runs 0..DEPTH, so it carries one bit more than the storage index.
module fetch_ret_stack
   import instr_fetch_unit_pkg::*;
#(
   parameter int WIDTH = ADDR_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SP_W  = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SP_W-1:0]  sp;
   logic [PTR_W-1:0] top_idx;

   assign top_idx = sp[PTR_W-1:0] - PTR_W'(1);
   assign full    = (sp == SP_W'(DEPTH));
   assign empty   = (sp == '0);
   assign dout    = mem[top_idx];

   // Push writes at sp then increments; pop only moves sp back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full) begin
         mem[sp[PTR_W-1:0]] <= din;
         sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
         sp <= sp - SP_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC with jump/call/return, fetch FSM driving the
// program-memory read handshake, IR register and sticky stack error.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ir_load,
   input  logic              pc_load,
   input  logic              jmp_en,
   input  logic              call_en,
   input  logic              ret_en,
   input  logic [ADDR_W-1:0] jmp_target,
   output logic [DATA_W-1:0] IR,
   output logic              ir_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stack_err
);

   ifu_state_t        state, state_nxt;
   pc_cmd_t           cmd;
   logic [ADDR_W-1:0] pc_nxt, pc_inc;
   logic              push, pop, err_set;
   logic [ADDR_W-1:0] stk_dout;
   logic              stk_full, stk_empty;
   logic              start_fetch, end_fetch;

   assign cmd    = '{ret: ret_en, call: call_en, jmp: jmp_en, inc: pc_load};
   assign pc_inc = pc + ADDR_W'(1);

   // The request is a flop output: state is registered and async-reset,
   // so reset drops mem_req without waiting for an edge.
   assign busy    = (state == IFU_WAIT);
   assign mem_req = busy;

   fetch_ret_stack #(
      .WIDTH (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Fetch FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IFU_IDLE;
      else        state <= state_nxt;
   end

   // Fetch FSM next state; ir_load during WAIT is simply not looked at.
   always_comb begin
      state_nxt   = state;
      start_fetch = 1'b0;
      end_fetch   = 1'b0;
      case (state)
         IFU_IDLE: if (ir_load) begin
            state_nxt   = IFU_WAIT;
            start_fetch = 1'b1;
         end
         IFU_WAIT: if (mem_ack) begin
            state_nxt = IFU_IDLE;
            end_fetch = 1'b1;
         end
         default: state_nxt = IFU_IDLE;
      endcase
   end

   // Address latched at request time so PC moves during WAIT can't disturb it;
   // IR/ir_valid follow the fetch lifecycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_addr <= '0;
         IR       <= '0;
         ir_valid <= 1'b0;
      end else if (start_fetch) begin
         mem_addr <= pc;
         ir_valid <= 1'b0;
      end else if (end_fetch) begin
         IR       <= mem_rdata;
         ir_valid <= 1'b1;
      end
   end

   // PC priority mux: ret > call > jmp > inc, one winner per cycle.
   always_comb begin
      pc_nxt  = pc;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      if (cmd.ret) begin
         if (stk_empty) err_set = 1'b1;
         else begin
            pop    = 1'b1;
            pc_nxt = stk_dout;
         end
      end else if (cmd.call) begin
         if (stk_full) err_set = 1'b1;
         else begin
            push   = 1'b1;
            pc_nxt = jmp_target;
         end
      end else if (cmd.jmp) begin
         pc_nxt = jmp_target;
      end else if (cmd.inc) begin
         pc_nxt = pc_inc;
      end
   end

   // PC and the sticky stack error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc        <= '0;
         stack_err <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (err_set) stack_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic       ir_load = 0, pc_load = 0, jmp_en = 0, call_en = 0, ret_en = 0;
   logic [7:0] jmp_target = '0;
   logic [7:0] IR;
   logic       ir_valid, busy, mem_req, stack_err;
   logic [7:0] pc, mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_ack = 0;

   logic [7:0] mem [256];
   assign mem_rdata = mem[mem_addr];

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 0;

   instr_fetch_unit dut (
      .clock(clock), .reset(reset), .ir_load(ir_load), .pc_load(pc_load),
      .jmp_en(jmp_en), .call_en(call_en), .ret_en(ret_en), .jmp_target(jmp_target),
      .IR(IR), .ir_valid(ir_valid), .busy(busy), .pc(pc), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stack_err(stack_err)
   );

   always #5 clock = ~clock;

   // Reference model: fetch in flight flag, PC, and return stack as a queue.
   bit         m_busy, m_valid, m_err;
   logic [7:0] m_pc, m_ir, m_addr;
   logic [7:0] m_stk [$];

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_valid = 0; m_err = 0;
         m_pc = 0; m_ir = 0; m_addr = 0;
         m_stk.delete();
      end else begin
         if (!m_busy) begin
            if (ir_load) begin m_busy = 1; m_addr = m_pc; m_valid = 0; end
         end else if (mem_ack) begin
            m_busy = 0; m_ir = mem[m_addr]; m_valid = 1;
         end
         if (ret_en) begin
            if (m_stk.size() == 0) m_err = 1;
            else m_pc = m_stk.pop_back();
         end else if (call_en) begin
            if (m_stk.size() == 4) m_err = 1;
            else begin m_stk.push_back(8'(m_pc + 8'd1)); m_pc = jmp_target; end
         end else if (jmp_en) m_pc = jmp_target;
         else if (pc_load) m_pc = 8'(m_pc + 8'd1);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("cyc.pc", pc, m_pc);
         chk("cyc.busy", {7'd0, busy}, {7'd0, m_busy});
         chk("cyc.mem_req", {7'd0, mem_req}, {7'd0, m_busy});
         if (m_busy) chk("cyc.mem_addr", mem_addr, m_addr);
         chk("cyc.ir_valid", {7'd0, ir_valid}, {7'd0, m_valid});
         chk("cyc.IR", IR, m_ir);
         chk("cyc.stack_err", {7'd0, stack_err}, {7'd0, m_err});
      end
   end

   task automatic cyc();
      @(posedge clock); #1;
   endtask

   task automatic clr();
      ir_load = 0; pc_load = 0; jmp_en = 0; call_en = 0; ret_en = 0; mem_ack = 0;
   endtask

   // Entered at posedge+1; reset stays clear of both clock edges.
   task automatic do_reset();
      clr();
      reset = 0; #3; reset = 1;
      cyc();
   endtask

   task automatic jump(input logic [7:0] t);
      jmp_en = 1; jmp_target = t; cyc(); clr();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h01;
      mem[8'h40] = 8'hAA;
      reset = 0;
      #2; reset = 1; #1; reset = 0;
      cyc();
      reset = 1;
      cmp_en = 1;
      cyc();
      chk("rst.pc", pc, 8'h00);
      chk("rst.IR", IR, 8'h00);
      chk("rst.mem_req", {7'd0, mem_req}, 8'h00);

      // 1: single fetch, ack in the first request cycle
      ir_load = 1; cyc(); clr();
      chk("t1.mem_req", {7'd0, mem_req}, 8'h01);
      chk("t1.mem_addr", mem_addr, 8'h00);
      mem_ack = 1; cyc(); clr();
      chk("t1.IR", IR, 8'h01);
      chk("t1.ir_valid", {7'd0, ir_valid}, 8'h01);
      chk("t1.mem_req_off", {7'd0, mem_req}, 8'h00);

      // 2: ack withheld, ir_load and jump during WAIT
      ir_load = 1; cyc(); clr();
      for (int i = 0; i < 5; i++) begin
         chk("t2.busy", {7'd0, busy}, 8'h01);
         chk("t2.mem_addr", mem_addr, 8'h00);
         if (i == 1) ir_load = 1;
         if (i == 2) begin jmp_en = 1; jmp_target = 8'h40; end
         cyc(); clr();
      end
      chk("t2.pc", pc, 8'h40);
      mem_ack = 1; cyc(); clr();
      chk("t2.IR", IR, 8'h01);
      chk("t2.busy_off", {7'd0, busy}, 8'h00);

      // 3: wrap and priority of jmp over pc_load
      jump(8'hFF);
      pc_load = 1; cyc(); clr();
      chk("t3.wrap", pc, 8'h00);
      pc_load = 1; jmp_en = 1; jmp_target = 8'h10; cyc(); clr();
      chk("t3.prio", pc, 8'h10);

      // 4: call/return, ret beats call
      jump(8'h05);
      call_en = 1; jmp_target = 8'h20; cyc(); clr();
      chk("t4.call", pc, 8'h20);
      ret_en = 1; cyc(); clr();
      chk("t4.ret", pc, 8'h06);
      call_en = 1; jmp_target = 8'h30; cyc(); clr();
      call_en = 1; ret_en = 1; jmp_target = 8'h50; cyc(); clr();
      chk("t4.ret_wins", pc, 8'h07);
      chk("t4.model_sp", 8'(m_stk.size()), 8'h00);
      chk("t4.no_err", {7'd0, stack_err}, 8'h00);

      // 5: overflow on fifth call, then underflow after reset
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         call_en = 1; jmp_target = 8'(i * 16); cyc(); clr();
         if (i == 4) chk("t5.err_before", {7'd0, stack_err}, 8'h00);
      end
      chk("t5.full_pc", pc, 8'h40);
      chk("t5.full_err", {7'd0, stack_err}, 8'h01);
      do_reset();
      ret_en = 1; cyc(); clr();
      chk("t5.empty_pc", pc, 8'h00);
      chk("t5.empty_err", {7'd0, stack_err}, 8'h01);
      repeat (3) cyc();
      chk("t5.sticky", {7'd0, stack_err}, 8'h01);

      // 6: asynchronous reset mid-fetch
      do_reset();
      jump(8'h33);
      ir_load = 1; cyc(); clr();
      chk("t6.busy", {7'd0, busy}, 8'h01);
      #2; reset = 0; #1;
      chk("t6.mem_req", {7'd0, mem_req}, 8'h00);
      chk("t6.busy_rst", {7'd0, busy}, 8'h00);
      chk("t6.pc", pc, 8'h00);
      chk("t6.mem_addr", mem_addr, 8'h00);
      #3; reset = 1;
      cyc();
      mem_ack = 1; cyc(); clr();
      chk("t6.late_ack", {7'd0, ir_valid}, 8'h00);
      chk("t6.idle", {7'd0, busy}, 8'h00);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         ir_load = ($urandom_range(0, 3) == 0);
         mem_ack = ($urandom_range(0, 2) == 0);
         pc_load = ($urandom_range(0, 2) == 0);
         jmp_en  = ($urandom_range(0, 7) == 0);
         call_en = ($urandom_range(0, 7) == 0);
         ret_en  = ($urandom_range(0, 7) == 0);
         jmp_target = 8'($urandom);
         cyc();
      end
      clr();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
